// File: rtl/rom_fetch_pkg.sv
// Shared types and limits for the ROM fetch controller.
// The PFETCH state exists only when ROM_PREFETCH_EN is defined.
package rom_fetch_pkg;

   localparam int AW_DEF      = 13;
   localparam int DW_DEF      = 8;
   localparam int LATENCY_DEF = 1;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 7;
   localparam int CNT_W       = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
`ifdef ROM_PREFETCH_EN
      HOLD  = 2'd2,
      PFETCH = 2'd3
`else
      HOLD  = 2'd2
`endif
   } fetch_state_e;

endpackage

// File: rtl/rom_prefetch_buf.sv
// One-entry prefetch buffer: tag, data and valid bit with hit compare.
// Only instantiated when ROM_PREFETCH_EN is defined.
module rom_prefetch_buf
   import rom_fetch_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic          inval,
   input  logic [AW-1:0] load_tag,
   input  logic [DW-1:0] load_data,
   input  logic [AW-1:0] cmp_addr,
   output logic          hit,
   output logic [DW-1:0] data
);

   logic          valid_q, valid_d;
   logic [AW-1:0] tag_q, tag_d;
   logic [DW-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (inval) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         tag_d   = load_tag;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign hit  = valid_q && (tag_q == cmp_addr);
   assign data = data_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// CPU-side fetch controller in front of a registered-output program ROM.
// Define ROM_PREFETCH_EN to add next-sequential-byte prefetch.
//
// state  | meaning
// IDLE   | no ROM access; waiting for cpu_rd_n low (prefetch buffer may hit)
// FETCH  | demand access in flight, CPU stalled; down-counter to capture
// HOLD   | fetched byte presented until cpu_rd_n rises
// PFETCH | speculative access of the next address (prefetch builds only)
module rom_fetch_ctrl
   import rom_fetch_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_rd_n,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_wait_n,
   output logic [AW-1:0] rom_a,
   output logic          rom_cs_n,
   input  logic [DW-1:0] rom_dout
);

   if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("rom_fetch_ctrl: LATENCY outside 1..7");
   end

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);

   fetch_state_e   state_q, state_d;
   logic [AW-1:0]  rom_a_q, rom_a_d;
   logic           rom_cs_n_q, rom_cs_n_d;
   logic [DW-1:0]  cpu_dout_q, cpu_dout_d;
   logic           cpu_wait_n_q, cpu_wait_n_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           abort_q, abort_d;

`ifdef ROM_PREFETCH_EN
   logic          buf_load, buf_inval, buf_hit;
   logic [DW-1:0] buf_data;

   rom_prefetch_buf #(.AW(AW), .DW(DW)) u_pf_buf (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (buf_load),
      .inval     (buf_inval),
      .load_tag  (rom_a_q),
      .load_data (rom_dout),
      .cmp_addr  (cpu_addr),
      .hit       (buf_hit),
      .data      (buf_data)
   );
`endif

   always_comb begin
      state_d      = state_q;
      rom_a_d      = rom_a_q;
      rom_cs_n_d   = rom_cs_n_q;
      cpu_dout_d   = cpu_dout_q;
      cpu_wait_n_d = cpu_wait_n_q;
      cnt_d        = cnt_q;
      abort_d      = abort_q;
`ifdef ROM_PREFETCH_EN
      buf_load     = 1'b0;
      buf_inval    = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (!cpu_rd_n) begin
`ifdef ROM_PREFETCH_EN
               if (buf_hit) begin
                  // rom_a tracks the served address so the next prefetch is A+1
                  rom_a_d    = cpu_addr;
                  cpu_dout_d = buf_data;
                  state_d    = HOLD;
               end else begin
                  rom_a_d      = cpu_addr;
                  rom_cs_n_d   = 1'b0;
                  cpu_wait_n_d = 1'b0;
                  cnt_d        = CNT_LOAD;
                  abort_d      = 1'b0;
                  state_d      = FETCH;
               end
`else
               rom_a_d      = cpu_addr;
               rom_cs_n_d   = 1'b0;
               cpu_wait_n_d = 1'b0;
               cnt_d        = CNT_LOAD;
               abort_d      = 1'b0;
               state_d      = FETCH;
`endif
            end
         end
         FETCH: begin
            if (cpu_rd_n) abort_d = 1'b1;
            if (cnt_q == '0) begin
               rom_cs_n_d   = 1'b1;
               cpu_wait_n_d = 1'b1;
               if (abort_q || cpu_rd_n) begin
                  state_d = IDLE;
               end else begin
                  cpu_dout_d = rom_dout;
                  state_d    = HOLD;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cpu_rd_n) begin
`ifdef ROM_PREFETCH_EN
               rom_a_d    = rom_a_q + AW'(1);
               rom_cs_n_d = 1'b0;
               cnt_d      = CNT_LOAD;
               state_d    = PFETCH;
`else
               state_d = IDLE;
`endif
            end
         end
`ifdef ROM_PREFETCH_EN
         PFETCH: begin
            if (!cpu_rd_n && (cpu_addr == rom_a_q)) begin
               if (cnt_q == '0) begin
                  // request lands on the completion edge: serve it directly
                  buf_load   = 1'b1;
                  cpu_dout_d = rom_dout;
                  rom_cs_n_d = 1'b1;
                  state_d    = HOLD;
               end else begin
                  cnt_d        = cnt_q - 1'b1;
                  cpu_wait_n_d = 1'b0;
                  abort_d      = 1'b0;
                  state_d      = FETCH;
               end
            end else if (!cpu_rd_n) begin
               buf_inval    = 1'b1;
               rom_a_d      = cpu_addr;
               rom_cs_n_d   = 1'b0;
               cpu_wait_n_d = 1'b0;
               cnt_d        = CNT_LOAD;
               abort_d      = 1'b0;
               state_d      = FETCH;
            end else if (cnt_q == '0) begin
               buf_load   = 1'b1;
               rom_cs_n_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rom_a_q      <= '0;
         rom_cs_n_q   <= 1'b1;
         cpu_dout_q   <= '0;
         cpu_wait_n_q <= 1'b1;
         cnt_q        <= '0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         rom_a_q      <= rom_a_d;
         rom_cs_n_q   <= rom_cs_n_d;
         cpu_dout_q   <= cpu_dout_d;
         cpu_wait_n_q <= cpu_wait_n_d;
         cnt_q        <= cnt_d;
         abort_q      <= abort_d;
      end
   end

   assign rom_a      = rom_a_q;
   assign rom_cs_n   = rom_cs_n_q;
   assign cpu_dout   = cpu_dout_q;
   assign cpu_wait_n = cpu_wait_n_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl with a registered LATENCY=1 ROM model.
// Expectations follow ROM_PREFETCH_EN, so it covers either build.
module tb_rom_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [12:0] cpu_addr;
   logic        cpu_rd_n;
   logic [7:0]  cpu_dout;
   logic        cpu_wait_n;
   logic [12:0] rom_a;
   logic        rom_cs_n;
   logic [7:0]  rom_dout = 8'h00;

   int checks = 0;
   int errors = 0;

`ifdef ROM_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   rom_fetch_ctrl #(.AW(13), .DW(8), .LATENCY(1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cpu_addr   (cpu_addr),
      .cpu_rd_n   (cpu_rd_n),
      .cpu_dout   (cpu_dout),
      .cpu_wait_n (cpu_wait_n),
      .rom_a      (rom_a),
      .rom_cs_n   (rom_cs_n),
      .rom_dout   (rom_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rom_cs_n) rom_dout <= rom_a[7:0] ^ 8'h5A;
   end

   typedef struct {
      logic [12:0] addr;
      int          gap;
      int          exp_wait;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Called on a negedge with cpu_rd_n already high; the strobe stays high
   // across 'gap' rising edges before the request is presented.
   task automatic do_read(input logic [12:0] a, input int gap, input int exp_wait,
                          input logic [7:0] exp_data, input string tag);
      int waits;
      bit done;
      repeat (gap - 1) @(negedge clk);
      @(negedge clk);
      cpu_addr = a;
      cpu_rd_n = 1'b0;
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (cpu_wait_n) done = 1'b1;
         else waits++;
      end
      check({tag, "_wait_cycles"}, 32'(waits), 32'(exp_wait));
      check({tag, "_data"}, {24'h0, cpu_dout}, {24'h0, exp_data});
      repeat (2) @(negedge clk);
      check({tag, "_held"}, {22'h0, rom_cs_n, cpu_wait_n, cpu_dout}, {22'h0, 1'b1, 1'b1, exp_data});
      cpu_rd_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{13'h0010, 2, 2,           8'h4A};
      vecs[1]  = '{13'h0000, 1, 2,           8'h5A};
      vecs[2]  = '{13'h0001, 1, PF ? 1 : 2,  8'h5B};
      vecs[3]  = '{13'h0100, 3, 2,           8'h5A};
      vecs[4]  = '{13'h0200, 1, 2,           8'h5A};
      vecs[5]  = '{13'h0100, 3, 2,           8'h5A};
      vecs[6]  = '{13'h0101, 3, PF ? 0 : 2,  8'h5B};
      vecs[7]  = '{13'h1FFF, 3, 2,           8'hA5};
      vecs[8]  = '{13'h0000, 3, PF ? 0 : 2,  8'h5A};
      vecs[9]  = '{13'h0001, 3, PF ? 0 : 2,  8'h5B};
      vecs[10] = '{13'h0001, 3, 2,           8'h5B};

      reset_n  = 1'b1;
      cpu_rd_n = 1'b1;
      cpu_addr = 13'h0;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rom_a", {19'h0, rom_a}, 32'h0);
      check("reset_ctl", {30'h0, rom_cs_n, cpu_wait_n}, 32'h3);
      check("reset_dout", {24'h0, cpu_dout}, 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_read(vecs[i].addr, vecs[i].gap, vecs[i].exp_wait, vecs[i].exp_data,
                 $sformatf("vec%0d", i));
      end

      // CPU abort: strobe released one cycle into FETCH
      repeat (2) @(negedge clk);
      @(negedge clk);
      cpu_addr = 13'h0033;
      cpu_rd_n = 1'b0;
      @(negedge clk);
      check("abort_wait_e0", {31'h0, cpu_wait_n}, 32'h0);
      cpu_rd_n = 1'b1;
      @(negedge clk);
      check("abort_wait_e1", {31'h0, cpu_wait_n}, 32'h0);
      @(negedge clk);
      check("abort_release", {22'h0, rom_cs_n, cpu_wait_n, cpu_dout}, {22'h0, 1'b1, 1'b1, 8'h5B});
      do_read(13'h0034, 1, 2, 8'h6E, "after_abort");

      // reset pulsed while a demand fetch is in flight
      repeat (3) @(negedge clk);
      @(negedge clk);
      cpu_addr = 13'h0077;
      cpu_rd_n = 1'b0;
      @(negedge clk);
      check("rst_mid_fetch_pre", {31'h0, cpu_wait_n}, 32'h0);
      #2 reset_n = 1'b0;
      #1;
      check("rst_mid_rom_a", {19'h0, rom_a}, 32'h0);
      check("rst_mid_ctl", {30'h0, rom_cs_n, cpu_wait_n}, 32'h3);
      check("rst_mid_dout", {24'h0, cpu_dout}, 32'h0);
      cpu_rd_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      do_read(13'h0078, 2, 2, 8'h22, "after_reset");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
